fifo_syn_prm: RTL and testbench
===============================

FIFO_SYN_PRM -- requirements
Module: fifo_syn_prm

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of 2, >=4.
REQ-003 Parameter SHOWAHEAD, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-005 Parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-006 Derived constant AW = log2(DEPTH), not user-settable.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 sclr  in  1  synchronous clear, active-high.
REQ-010 wr  in  1  write request.
REQ-011 data  in  WIDTH  write data.
REQ-012 rd  in  1  read request (pop).
REQ-013 q  out  WIDTH  read data.
REQ-014 full  out  1  usedw == DEPTH.
REQ-015 empty  out  1  usedw == 0.
REQ-016 almost_full  out  1  usedw >= AF_LEVEL.
REQ-017 almost_empty  out  1  usedw <= AE_LEVEL.
REQ-018 usedw  out  AW+1  stored word count, range 0..DEPTH inclusive.
REQ-019 overflow  out  1  sticky: write attempted while full.
REQ-020 underflow  out  1  sticky: read attempted while empty.

Function
REQ-021 Write accepted (wr_acc) SHALL be wr & ~full & ~sclr; accepted word stored at write pointer, pointer +1.
REQ-022 Read accepted (rd_acc) SHALL be rd & ~empty & ~sclr; read pointer +1.
REQ-023 Pointers SHALL be AW+1 bits, wrap modulo 2*DEPTH; memory addressed by low AW bits.
REQ-024 usedw SHALL be registered: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-025 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered usedw; no combinational path from wr/rd.
REQ-026 wr while full SHALL be dropped even if rd accepted same cycle (no full-bypass); overflow set next edge.
REQ-027 rd while empty SHALL be dropped even if wr accepted same cycle; underflow set next edge; q unchanged.
REQ-028 SHOWAHEAD=0: q SHALL load head word on the edge of rd_acc (1-cycle latency) and hold otherwise.
REQ-029 SHOWAHEAD=1: q SHALL present head word whenever ~empty; first write visible on q one cycle after wr_acc; q value undefined-but-stable content of head slot while empty is permitted only as 0 after reset/sclr until first write.
REQ-030 Data order SHALL be strict FIFO across pointer wrap-around.
REQ-031 sclr SHALL zero pointers, usedw, overflow, underflow and (SHOWAHEAD=0) q on next edge, overriding wr/rd that cycle.
REQ-032 overflow/underflow SHALL clear only on rst_n or sclr.

Reset
REQ-033 rst_n low SHALL immediately force pointers, usedw, q, overflow, underflow to 0; empty=1, full=0, almost_empty=1, almost_full=0.
REQ-034 Memory array SHALL NOT be reset; reset mid-operation discards all content.
REQ-035 Reset release SHALL be synchronous to clk externally; first wr may be accepted on the first edge after release.

Structure
REQ-036 Shared package fifo_pkg SHALL hold the clog2 function and default WIDTH/DEPTH constants.
REQ-037 Storage SHALL be sub-module fifo_syn_ram: simple dual-port, synchronous write, asynchronous read, WIDTH x DEPTH, inferable as block RAM.
REQ-038 Parameter legality (DEPTH power of 2, AE_LEVEL < AF_LEVEL <= DEPTH) SHALL be checked at elaboration.

Verification (WIDTH=8, DEPTH=16, defaults unless stated)
REQ-039 Write 0x01..0x10 -> full=1, usedw=16, almost_full high from usedw=14; 17th write dropped, overflow=1.
REQ-040 SHOWAHEAD=0, then 16 reads -> q sequence 0x01..0x10 each one cycle after rd; empty=1 after last; extra rd -> underflow=1, q stays 0x10.
REQ-041 Fill 10, then 40 cycles simultaneous wr/rd with incrementing data -> usedw stays 10, output order matches input across wrap.
REQ-042 Full plus simultaneous wr+rd -> usedw=15, overflow=1; empty plus wr+rd -> usedw=1, underflow=1.
REQ-043 SHOWAHEAD=1: write 0xA5 at cycle n -> q=0xA5, empty=0 at n+1 without rd; rd pops, empty=1 next cycle.
REQ-044 Fill 8, assert sclr with wr=1 -> usedw=0, empty=1, flags 0; async rst_n pulse mid-stream -> same values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared constants and helpers for the synchronous FIFO.
// Rev 1.0
`default_nettype none

package fifo_pkg;

  localparam int C_DEF_WIDTH = 8;
  localparam int C_DEF_DEPTH = 16;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_syn_ram.sv
// fifo_syn_ram -- simple dual-port storage, synchronous write, asynchronous read.
// Rev 1.0
`default_nettype none

module fifo_syn_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // No reset on the array so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_syn_prm.sv
// fifo_syn_prm -- single-clock parameterised FIFO with level flags and sticky errors.
// Rev 1.0
`default_nettype none

module fifo_syn_prm
  import fifo_pkg::*;
#(
  parameter int WIDTH     = C_DEF_WIDTH,
  parameter int DEPTH     = C_DEF_DEPTH,
  parameter int SHOWAHEAD = 0,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclr,
  input  logic               wr,
  input  logic [WIDTH-1:0]   data,
  input  logic               rd,
  output logic [WIDTH-1:0]   q,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [clog2(DEPTH):0] usedw,
  output logic               overflow,
  output logic               underflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] C_AE    = (AW+1)'(AE_LEVEL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH)
  begin : g_bad_params
    $error("fifo_syn_prm: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      r_usedw;
  logic             r_ovf;
  logic             r_udf;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_rdata;
  logic             w_unused_ptr_msb;

  assign w_wr_acc = wr & ~full & ~sclr;
  assign w_rd_acc = rd & ~empty & ~sclr;

  // Flags decode only the registered count, never wr/rd.
  assign usedw        = r_usedw;
  assign full         = (r_usedw == C_DEPTH);
  assign empty        = (r_usedw == '0);
  assign almost_full  = (r_usedw >= C_AF);
  assign almost_empty = (r_usedw <= C_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // Pointer MSBs only carry the wrap lap; the RAM sees the low bits.
  assign w_unused_ptr_msb = r_wptr[AW] ^ r_rptr[AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usedw <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (sclr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usedw <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + C_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + C_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_usedw <= r_usedw + C_ONE;
        2'b01:   r_usedw <= r_usedw - C_ONE;
        default: r_usedw <= r_usedw;
      endcase
      if (wr && full)  r_ovf <= 1'b1;
      if (rd && empty) r_udf <= 1'b1;
    end
  end

  fifo_syn_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (data),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  if (SHOWAHEAD != 0) begin : g_showahead
    // Head slot is forced to zero while empty so q is stable and defined.
    assign q = empty ? '0 : w_rdata;
  end else begin : g_registered
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_q <= '0;
      else if (sclr)     r_q <= '0;
      else if (w_rd_acc) r_q <= w_rdata;
    end
    assign q = r_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_syn_prm.sv
// tb_fifo_syn_prm -- directed and random checks of both read modes against a queue model.
// Rev 1.0
`default_nettype none

module tb_fifo_syn_prm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data = 8'h00;

  logic [7:0] q0, q1;
  logic [4:0] usedw0, usedw1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_fifo[$];
  logic [7:0] m_q;
  bit         m_ovf;
  bit         m_udf;

  always #5 clk = ~clk;

  fifo_syn_prm #(.WIDTH(8), .DEPTH(16), .SHOWAHEAD(0)) u_dut_reg (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wr(wr), .data(data), .rd(rd),
    .q(q0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .usedw(usedw0), .overflow(ovf0), .underflow(udf0)
  );

  fifo_syn_prm #(.WIDTH(8), .DEPTH(16), .SHOWAHEAD(1)) u_dut_sa (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wr(wr), .data(data), .rd(rd),
    .q(q1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .usedw(usedw1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_q   = 8'h00;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    logic [7:0] head;
    n    = m_fifo.size();
    head = (n > 0) ? m_fifo[0] : 8'h00;
    check_val("usedw",      usedw0, n);
    check_val("full",       full0,  n == 16);
    check_val("empty",      empty0, n == 0);
    check_val("almost_full",  af0,  n >= 14);
    check_val("almost_empty", ae0,  n <= 2);
    check_val("overflow",   ovf0,   m_ovf);
    check_val("underflow",  udf0,   m_udf);
    check_val("q_reg",      q0,     m_q);
    check_val("sa_usedw",   usedw1, n);
    check_val("sa_flags",   {full1, empty1, af1, ae1}, {n == 16, n == 0, n >= 14, n <= 2});
    check_val("sa_errs",    {ovf1, udf1}, {m_ovf, m_udf});
    check_val("q_showahead", q1,    head);
  endtask

  task automatic cycle(input bit w, input bit r, input bit s, input logic [7:0] d);
    int n;
    wr = w; rd = r; sclr = s; data = d;
    @(posedge clk);
    n = m_fifo.size();
    if (s) begin
      model_clear();
    end else begin
      if (w && n == 16) m_ovf = 1'b1;
      if (r && n == 0)  m_udf = 1'b1;
      if (r && n > 0)   m_q = m_fifo.pop_front();
      if (w && n < 16)  m_fifo.push_back(d);
    end
    #1 check_all();
  endtask

  initial begin
    logic [7:0] seq;
    int wp, rp;
    model_clear();
    #12 check_all();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) cycle(1, 0, 0, 8'(i));
    cycle(1, 0, 0, 8'h11);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);

    cycle(0, 0, 1, 8'h00);
    seq = 8'h20;
    for (int i = 0; i < 10; i++) begin cycle(1, 0, 0, seq); seq++; end
    for (int i = 0; i < 40; i++) begin cycle(1, 1, 0, seq); seq++; end

    for (int i = 0; i < 6; i++) begin cycle(1, 0, 0, seq); seq++; end
    cycle(1, 1, 0, 8'hEE);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'hA5);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);

    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h40 + i));
    cycle(1, 0, 1, 8'h55);
    cycle(1, 0, 0, 8'hA5);
    cycle(0, 1, 0, 8'h00);

    for (int blk = 0; blk < 12; blk++) begin
      wp = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 15 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 40; i++)
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
              $urandom_range(0, 199) == 0, 8'($urandom));
    end

    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'($urandom));
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    cycle(1, 0, 0, 8'h3C);
    cycle(0, 1, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
